torque_led_display: RTL

Parametrised successor to the direction-only LED indicator. It drives the two red-LED banks (left bank LEDR[17:9], right bank LEDR[8:0] at default width) as a torque bar graph whose fill direction and per-side length follow motor direction and torque magnitude. It adds direction debouncing, a ramped display level, an idle chase animation and an emergency-stop blink. It sits between the motor command logic and the board LED pins.

---
 rtl/torque_led_display.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/torque_led_display.sv
// torque_led_display: bar-graph torque indicator for two LED banks.
// Shows a ramped bar whose shape follows the debounced motor direction.
// Runs an idle chase when there is no torque.
// An emergency stop overrides everything with a blink.
module torque_led_display #(
    parameter int N_LED       = 9,
    parameter int MAG_W       = 4,
    parameter int TICK_DIV    = 500000,
    parameter int HOLD_TICKS  = 3,
    parameter int BLINK_TICKS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       direc,
    input  logic [MAG_W-1:0] mag,
    input  logic             estop,
    output logic [N_LED-1:0] left_LED,
    output logic [N_LED-1:0] right_LED,
    output logic [1:0]       dir_shown
);

    localparam int LW = $clog2(N_LED + 1);
    localparam int PW = $clog2(2 * N_LED);
    localparam int TW = MAG_W + LW + 1;
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int BW = $clog2(BLINK_TICKS + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_ESTOP} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   presc_reg;
    logic [LW-1:0]   level_reg, level_next;
    logic [PW-1:0]   pos_reg, pos_next;
    logic [1:0]      dir_reg, dir_next;
    logic [1:0]      cand_reg, cand_next;
    logic [HW-1:0]   hold_reg, hold_next, hold_calc;
    logic [BW-1:0]   phase_reg, phase_next;
    logic            blink_reg, blink_next;
    logic            tick;
    logic            commit;
    logic [LW-1:0]   step;
    logic [LW-1:0]   half_level;
    logic [TW-1:0]   prod;
    logic [LW-1:0]   tgt;
    logic [N_LED-1:0] f_full, f_half, r_full, chase_l, chase_r;
    logic [N_LED-1:0] left_next, right_next;

    // Rounded-up scaling so any nonzero magnitude lights at least one LED.
    assign prod       = TW'(mag) * TW'(N_LED) + TW'((2 ** MAG_W) - 1);
    assign tgt        = LW'(prod >> MAG_W);
    assign tick       = (presc_reg == CW'(TICK_DIV - 1));
    assign half_level = level_reg >> 1;
    assign dir_shown  = dir_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_LED; gi++) begin : g_bar
            assign f_full[gi]  = (LW'(gi) < level_reg);
            assign f_half[gi]  = (LW'(gi) < half_level);
            assign r_full[gi]  = (((LW+1)'(gi) + {1'b0, level_reg}) >= (LW+1)'(N_LED));
            assign chase_l[gi] = (pos_reg == PW'(gi));
            assign chase_r[gi] = (pos_reg == PW'(gi + N_LED));
        end
    endgenerate

    // Free-running display tick prescaler.
    always_ff @(posedge clk) begin
        if (reset) presc_reg <= '0;
        else       presc_reg <= tick ? '0 : presc_reg + 1'b1;
    end

    // Next-state logic: estop override, debounce, ramp and chase.
    always_comb begin
        state_next = state_reg;
        level_next = level_reg;
        pos_next   = pos_reg;
        dir_next   = dir_reg;
        cand_next  = cand_reg;
        hold_next  = hold_reg;
        phase_next = phase_reg;
        blink_next = blink_reg;
        commit     = 1'b0;
        if (level_reg < tgt)      step = level_reg + 1'b1;
        else if (level_reg > tgt) step = level_reg - 1'b1;
        else                      step = level_reg;
        if (direc == dir_reg)       hold_calc = '0;
        else if (direc == cand_reg) hold_calc = hold_reg + 1'b1;
        else                        hold_calc = HW'(1);

        if (estop) begin
            if (state_reg != ST_ESTOP) begin
                state_next = ST_ESTOP;
                phase_next = '0;
                blink_next = 1'b1;
            end else if (tick) begin
                if (phase_reg == BW'(BLINK_TICKS - 1)) begin
                    phase_next = '0;
                    blink_next = ~blink_reg;
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
        end else if (state_reg == ST_ESTOP) begin
            state_next = ST_IDLE;
            level_next = '0;
            pos_next   = '0;
        end else if (tick) begin
            if (direc != dir_reg && direc != cand_reg) cand_next = direc;
            hold_next = hold_calc;
            if (hold_calc == HW'(HOLD_TICKS)) begin
                commit    = 1'b1;
                dir_next  = cand_next;
                hold_next = '0;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (tgt != '0) begin
                        state_next = ST_RUN;
                        level_next = commit ? LW'(0) : LW'(1);
                    end else begin
                        pos_next = (pos_reg == PW'(2 * N_LED - 1)) ? '0 : pos_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                    level_next = commit ? '0 : step;
                    // A fresh direction restarts the ramp but keeps RUN while torque remains.
                    if ((commit || step == '0) && tgt == '0) begin
                        state_next = ST_IDLE;
                        pos_next   = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            level_reg <= '0;
            pos_reg   <= '0;
            dir_reg   <= 2'b00;
            cand_reg  <= 2'b00;
            hold_reg  <= '0;
            phase_reg <= '0;
            blink_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            level_reg <= level_next;
            pos_reg   <= pos_next;
            dir_reg   <= dir_next;
            cand_reg  <= cand_next;
            hold_reg  <= hold_next;
            phase_reg <= phase_next;
            blink_reg <= blink_next;
        end
    end

    // Pattern decode of the current state.
    always_comb begin
        left_next  = '0;
        right_next = '0;
        case (state_reg)
            ST_IDLE: begin
                left_next  = chase_l;
                right_next = chase_r;
            end
            ST_RUN: begin
                case (dir_reg)
                    2'b00:   begin left_next = f_full; right_next = f_full; end
                    2'b01:   begin left_next = r_full; right_next = r_full; end
                    2'b10:   begin left_next = f_half; right_next = f_full; end
                    default: begin left_next = f_full; right_next = f_half; end
                endcase
            end
            ST_ESTOP: begin
                left_next  = {N_LED{blink_reg}};
                right_next = {N_LED{blink_reg}};
            end
            default: ;
        endcase
    end

    // Registered LED outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            left_LED  <= '0;
            right_LED <= '0;
        end else begin
            left_LED  <= left_next;
            right_LED <= right_next;
        end
    end

endmodule
